// File: rtl/ifu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ifu_pkg
// Brief    : Shared widths, reset PC and redirect-target helpers for the IFU.
// Revision : 1.0
// ============================================================================
package ifu_pkg;

    localparam int              XLEN             = 32;
    localparam int              INSTR_W          = 32;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    // Region-relative jump: keep the top nibble of the sequential PC.
    function automatic logic [XLEN-1:0] calc_j_addr(input logic [XLEN-1:0] pc,
                                                    input logic [25:0]     index);
        return ((pc + 32'd4) & 32'hF000_0000) | {4'b0000, index, 2'b00};
    endfunction

    function automatic logic [XLEN-1:0] calc_b_addr(input logic [XLEN-1:0] pc,
                                                    input logic [15:0]     imm);
        return pc + 32'd4 + {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : fetch_queue
// Brief    : Registered circular FIFO holding fetched {pc, instr} entries.
// Revision : 1.0
// ============================================================================
module fetch_queue #(
    parameter int  DEPTH   = 4,
    parameter int  WIDTH   = 64,
    localparam int c_CNT_W = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               push,
    input  logic [WIDTH-1:0]   push_data,
    input  logic               pop,
    output logic [WIDTH-1:0]   head_data,
    output logic               full,
    output logic               empty,
    output logic [c_CNT_W-1:0] count
);

    localparam int c_PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic               w_pop;

    assign w_pop     = pop & ~empty;
    assign head_data = r_mem[r_rd_ptr];
    assign empty     = (r_count == '0);
    assign full      = (r_count == c_CNT_W'(DEPTH));
    assign count     = r_count;

    // Storage is cleared on reset so the head reads zero before any fetch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push) begin
                r_mem[r_wr_ptr] <= push_data;
                r_wr_ptr        <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            r_count <= r_count + c_CNT_W'(push) - c_CNT_W'(w_pop);
        end
    end

endmodule

`default_nettype wire

// File: rtl/instruction_prefetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : instruction_prefetch_unit
// Brief    : Sequential instruction prefetcher with jump/branch redirect.
// Revision : 1.0
// ============================================================================
module instruction_prefetch_unit
    import ifu_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output logic [XLEN-1:0]    imem_req_addr,
    input  logic               imem_resp_valid,
    input  logic [INSTR_W-1:0] imem_resp_data,
    output logic               if_valid,
    output logic [INSTR_W-1:0] if_instr,
    output logic [XLEN-1:0]    if_pc,
    input  logic               id_ready,
    input  logic               jump_target,
    input  logic               jump_branch,
    input  logic [XLEN-1:0]    pc_id,
    input  logic [25:0]        instr_id
);

    localparam int               c_CNT_W     = $clog2(DEPTH + 1);
    localparam int               c_PTR_W     = $clog2(DEPTH);
    localparam logic [c_CNT_W:0] c_DEPTH_EXT = (c_CNT_W + 1)'(DEPTH);

    logic [XLEN-1:0]    r_fetch_pc;
    logic [c_CNT_W-1:0] r_outstanding;
    logic [c_CNT_W-1:0] r_discard;
    logic [XLEN-1:0]    r_pc_fifo [DEPTH];
    logic [c_PTR_W-1:0] r_pcf_wr_ptr;
    logic [c_PTR_W-1:0] r_pcf_rd_ptr;

    logic               w_redirect;
    logic [XLEN-1:0]    w_target;
    logic [c_CNT_W:0]   w_in_flight;
    logic               w_accept;
    logic               w_resp_keep;
    logic               w_q_push;
    logic               w_q_pop;
    logic               w_q_full;
    logic               w_q_empty;
    logic [c_CNT_W-1:0] w_q_count;
    fetch_entry_t       w_push_entry;
    fetch_entry_t       w_head_entry;

    assign w_redirect  = jump_target | jump_branch;
    assign w_target    = jump_target ? calc_j_addr(pc_id, instr_id)
                                     : calc_b_addr(pc_id, instr_id[15:0]);
    // Queued plus in-flight never exceeds DEPTH, so every response has a slot.
    assign w_in_flight = {1'b0, w_q_count} + {1'b0, r_outstanding};

    assign imem_req_valid = ~rst & ~w_redirect & (w_in_flight < c_DEPTH_EXT);
    assign imem_req_addr  = r_fetch_pc;
    assign w_accept       = imem_req_valid & imem_req_ready;

    assign w_resp_keep  = imem_resp_valid & ~w_redirect & (r_discard == '0);
    assign w_q_push     = w_resp_keep & ~w_q_full;
    assign w_q_pop      = ~w_q_empty & id_ready & ~w_redirect;
    assign w_push_entry = '{pc: r_pc_fifo[r_pcf_rd_ptr], instr: imem_resp_data};

    assign if_valid = ~w_q_empty;
    assign if_pc    = w_head_entry.pc;
    assign if_instr = w_head_entry.instr;

    fetch_queue #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(fetch_entry_t))
    ) u_fetch_queue (
        .clk       (clk),
        .rst       (rst),
        .flush     (w_redirect),
        .push      (w_q_push),
        .push_data (w_push_entry),
        .pop       (w_q_pop),
        .head_data (w_head_entry),
        .full      (w_q_full),
        .empty     (w_q_empty),
        .count     (w_q_count)
    );

    // Outstanding counts every in-flight request, including ones to be discarded.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_pc    <= RESET_PC;
            r_outstanding <= '0;
            r_discard     <= '0;
        end else begin
            r_outstanding <= r_outstanding + c_CNT_W'(w_accept) - c_CNT_W'(imem_resp_valid);
            if (w_redirect) begin
                r_fetch_pc <= w_target;
                r_discard  <= r_outstanding - c_CNT_W'(imem_resp_valid);
            end else begin
                if (w_accept) begin
                    r_fetch_pc <= r_fetch_pc + XLEN'(4);
                end
                if (imem_resp_valid && (r_discard != '0)) begin
                    r_discard <= r_discard - c_CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pcf_wr_ptr <= '0;
            r_pcf_rd_ptr <= '0;
        end else if (w_redirect) begin
            r_pcf_wr_ptr <= '0;
            r_pcf_rd_ptr <= '0;
        end else begin
            if (w_accept) begin
                r_pcf_wr_ptr <= r_pcf_wr_ptr + c_PTR_W'(1);
            end
            if (w_resp_keep) begin
                r_pcf_rd_ptr <= r_pcf_rd_ptr + c_PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_pc_fifo[r_pcf_wr_ptr] <= r_fetch_pc;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_instruction_prefetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_instruction_prefetch_unit
// Brief    : Randomised bench with an in-order memory and epoch-based model.
// Revision : 1.0
// ============================================================================
module tb_instruction_prefetch_unit;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk             = 1'b0;
    logic        rst             = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready  = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data  = '0;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        id_ready        = 1'b0;
    logic        jump_target     = 1'b0;
    logic        jump_branch     = 1'b0;
    logic [31:0] pc_id           = '0;
    logic [25:0] instr_id        = '0;

    instruction_prefetch_unit #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .if_valid        (if_valid),
        .if_instr        (if_instr),
        .if_pc           (if_pc),
        .id_ready        (id_ready),
        .jump_target     (jump_target),
        .jump_branch     (jump_branch),
        .pc_id           (pc_id),
        .instr_id        (instr_id)
    );

    always #5 clk = ~clk;

    // Memory-side request record: actual address drives data, expected PC drives checks.
    typedef struct {
        logic [31:0] addr;
        logic [31:0] pc;
        int          epoch;
        int          due;
    } pend_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    pend_t       pend[$];
    ent_t        mq[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          last_due = 0;
    int          epoch    = 0;
    int          acc_cnt  = 0;
    int          lat_min  = 1;
    int          lat_max  = 1;
    logic [31:0] exp_req  = RESET_PC;
    logic        got;
    logic [31:0] first_pc;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] model_target(input logic jt, input logic [31:0] pcid,
                                                 input logic [25:0] iid);
        logic [31:0] next_pc;
        int          off;
        next_pc = pcid + 32'd4;
        if (jt) return (next_pc & 32'hF000_0000) | (32'(iid) << 2);
        off = int'($signed(iid[15:0]));
        return next_pc + 32'(off * 4);
    endfunction

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // One clock cycle: drive at negedge, check at negedge+1, update model for the edge.
    task automatic step(input logic jt, input logic jb, input logic rdy, input logic idr,
                        input logic [31:0] pcid, input logic [25:0] iid);
        pend_t r;
        logic  rv;
        logic  red;
        logic  exp_v;
        int    due;
        r.addr = '0; r.pc = '0; r.epoch = 0; r.due = 0;
        rv = 1'b0;
        @(negedge clk);
        if (pend.size() != 0 && pend[0].due <= cyc) begin
            r  = pend.pop_front();
            rv = 1'b1;
        end
        imem_resp_valid = rv;
        imem_resp_data  = rv ? mem_word(r.addr) : $urandom;
        imem_req_ready  = rdy;
        id_ready        = idr;
        jump_target     = jt;
        jump_branch     = jb;
        pc_id           = pcid;
        instr_id        = iid;
        #1;
        red   = jt | jb;
        exp_v = !red && ((mq.size() + pend.size() + int'(rv)) < DEPTH);
        chk("req_valid", imem_req_valid, exp_v);
        chk("req_addr", imem_req_addr, exp_req);
        chk("if_valid", if_valid, mq.size() != 0);
        if (mq.size() != 0) begin
            chk("if_pc", if_pc, mq[0].pc);
            chk("if_instr", if_instr, mq[0].instr);
        end
        if (imem_req_valid && rdy) begin
            acc_cnt++;
            due = cyc + $urandom_range(lat_max, lat_min);
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            pend.push_back('{addr: imem_req_addr, pc: exp_req, epoch: epoch, due: due});
            if (!red) exp_req = exp_req + 32'd4;
        end
        if (red) begin
            exp_req = model_target(jt, pcid, iid);
            epoch++;
            mq.delete();
        end else begin
            if (mq.size() != 0 && idr) mq.delete(0);
            if (rv && r.epoch == epoch) mq.push_back('{pc: r.pc, instr: mem_word(r.pc)});
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst             = 1'b1;
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        id_ready        = 1'b0;
        jump_target     = 1'b0;
        jump_branch     = 1'b0;
        pc_id           = '0;
        instr_id        = '0;
        #1;
        chk("rst_req_valid", imem_req_valid, 0);
        chk("rst_if_valid", if_valid, 0);
        repeat (n) @(negedge clk);
        #1;
        chk("rst_req_valid_hold", imem_req_valid, 0);
        chk("rst_if_pc", if_pc, 0);
        chk("rst_if_instr", if_instr, 0);
        chk("rst_req_addr", imem_req_addr, RESET_PC);
        rst = 1'b0;
        pend.delete();
        mq.delete();
        exp_req  = RESET_PC;
        epoch++;
        last_due = cyc;
        @(posedge clk);
        #1;
        cyc++;
        chk("first_req_valid", imem_req_valid, 1);
    endtask

    task automatic drain();
        int n = 0;
        while ((pend.size() != 0 || mq.size() != 0) && n < 60) begin
            step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 26'h0);
            n++;
        end
        chk("drain_done", pend.size() + mq.size(), 0);
    endtask

    initial begin
        do_reset(3);

        // Decode stalled: exactly DEPTH requests go out, nothing is lost.
        acc_cnt = 0;
        repeat (10) step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 26'h0);
        chk("stall_accepts", acc_cnt, DEPTH);
        repeat (12) step(1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 26'h0);
        drain();

        step(1'b1, 1'b0, 1'b1, 1'b1, 32'h1000_0010, 26'h000_0040);
        chk("jump_addr", imem_req_addr, 32'h1000_0100);
        chk("jump_flush", if_valid, 0);
        drain();

        step(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0100, 26'h000_FFFE);
        chk("branch_addr", imem_req_addr, 32'h0000_00FC);
        drain();

        // Three requests in flight with 3-cycle latency, then redirect to 0x200.
        lat_min = 3;
        lat_max = 3;
        repeat (3) step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 26'h0);
        step(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0000, 26'h000_0080);
        got      = 1'b0;
        first_pc = '0;
        repeat (12) begin
            step(1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 26'h0);
            if (!got && if_valid) begin
                got      = 1'b1;
                first_pc = if_pc;
            end
        end
        chk("redir_seen", got, 1);
        chk("redir_first_pc", first_pc, 32'h0000_0200);
        lat_min = 1;
        lat_max = 4;
        drain();

        step(1'b0, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFF8, 26'h0);
        chk("wrap_pre_addr", imem_req_addr, 32'hFFFF_FFFC);
        step(1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 26'h0);
        chk("wrap_addr", imem_req_addr, 32'h0000_0000);

        repeat (1500) step($urandom_range(0, 99) < 4, $urandom_range(0, 99) < 4,
                           $urandom_range(0, 99) < 75, $urandom_range(0, 99) < 70,
                           $urandom, 26'($urandom));

        do_reset(2);
        repeat (300) step($urandom_range(0, 99) < 4, $urandom_range(0, 99) < 4,
                          $urandom_range(0, 99) < 75, $urandom_range(0, 99) < 70,
                          $urandom, 26'($urandom));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/instruction_prefetch_unit.md
INSTRUCTION_PREFETCH_UNIT -- requirements
Module: instruction_prefetch_unit

Interface
REQ-001 Parameter DEPTH, default 4, prefetch queue entries (power of two, 2..16).
REQ-002 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-003 The block SHALL use one clock and an asynchronous, active-high reset: clk (input, 1) is the sole clock; rst (input, 1) is the asynchronous active-high reset.
REQ-004 imem_req_valid  output  1  fetch request to instruction memory.
REQ-005 imem_req_ready  input  1  memory accepts request this cycle.
REQ-006 imem_req_addr  output  32  word-aligned fetch address.
REQ-007 imem_resp_valid  input  1  in-order response for an accepted request.
REQ-008 imem_resp_data  input  32  instruction word.
REQ-009 if_valid  output  1  queue head valid to decode.
REQ-010 if_instr  output  32  queue head instruction.
REQ-011 if_pc  output  32  queue head PC.
REQ-012 id_ready  input  1  decode consumes head when if_valid and id_ready.
REQ-013 jump_target  input  1  redirect to jump address.
REQ-014 jump_branch  input  1  redirect to branch address (ignored if jump_target high).
REQ-015 pc_id  input  32  PC of instruction in decode.
REQ-016 instr_id  input  26  low 26 bits of instruction in decode.

Function
REQ-017 j_addr SHALL equal {pc_id_p4[31:28], instr_id[25:0], 2'b00}, pc_id_p4 = pc_id + 4 modulo 2^32.
REQ-018 b_addr SHALL equal pc_id_p4 + (sign-extended instr_id[15:0] << 2), modulo 2^32.
REQ-019 redirect = jump_target | jump_branch; target = jump_target ? j_addr : b_addr.
REQ-020 fetch_pc register SHALL advance by 4 on each accepted request (imem_req_valid & imem_req_ready), wrapping modulo 2^32.
REQ-021 imem_req_addr SHALL equal fetch_pc.
REQ-022 imem_req_valid SHALL be high iff not redirect and (queue occupancy + outstanding) < DEPTH.
REQ-023 outstanding counter (0..DEPTH) SHALL increment on accept, decrement on response, both same cycle = unchanged.
REQ-024 Each response not marked for discard SHALL push {fetch-time PC, imem_resp_data} into the queue; responses return strictly in request order.
REQ-025 Queue SHALL never overflow; REQ-022 guarantees space for every outstanding response.
REQ-026 Head SHALL pop when if_valid & id_ready; push and pop in same cycle SHALL both occur, occupancy unchanged.
REQ-027 Response-to-if_valid latency SHALL be one cycle when queue empty (registered queue, no bypass).
REQ-028 On redirect cycle: queue flushed (occupancy 0 next cycle, if_valid low), fetch_pc <= target, no request issued, pop ignored.
REQ-029 On redirect: discard counter <= outstanding minus (1 if imem_resp_valid that cycle); that response also dropped.
REQ-030 While discard counter > 0, each response SHALL decrement it and SHALL NOT push.
REQ-031 Redirect while discard counter > 0 SHALL apply REQ-029 using current outstanding (superset of prior discards).
REQ-032 Back-to-back redirects SHALL each take effect; last one determines fetch_pc.
REQ-033 imem_req_ready low SHALL hold fetch_pc and imem_req_addr stable.

Reset
REQ-034 On rst: fetch_pc = RESET_PC, occupancy = 0, outstanding = 0, discard = 0, if_valid = 0, imem_req_valid = 0 while rst asserted.
REQ-035 if_instr/if_pc SHALL read 0 out of reset; rst mid-transaction drops all in-flight responses (memory side reset together).
REQ-036 First request SHALL issue on the first cycle after rst deasserts.

Structure
REQ-037 Shared package ifu_pkg SHALL hold RESET_PC default, XLEN=32, INSTR_W=32 and the target-address helper functions.
REQ-038 Queue SHALL be a sub-module fetch_queue (parametrised DEPTH x 64-bit, flush, push, pop, full, empty, count).
REQ-039 In-flight PC tracking SHALL be a DEPTH-entry PC FIFO inside the top module, flushed on redirect alongside discard logic.

Verification
REQ-040 Reset, ready=1, 1-cycle memory: addresses 0x0,0x4,0x8,0xC issued; if_pc sequence 0x0,0x4,... with id_ready=1.
REQ-041 id_ready=0, DEPTH=4: exactly 4 requests accepted, then imem_req_valid low; 4 entries held, none lost.
REQ-042 jump_target, pc_id=0x1000_0010, instr_id=0x0000040 -> next request addr 0x1000_0100; queue empty next cycle.
REQ-043 jump_branch, pc_id=0x0000_0100, instr_id[15:0]=0xFFFE -> next addr 0x0000_00FC.
REQ-044 3 outstanding, 3-cycle memory latency, redirect to 0x200 -> 3 old responses dropped, first if_pc = 0x200.
REQ-045 fetch_pc=0xFFFF_FFFC accepted -> next request addr 0x0000_0000.
